// File: rtl/mcpu_mem_arb_pkg.sv
// Shared types for the two-master DRAM Avalon arbiter: FSM states and read-queue entries.
package mcpu_mem_arb_pkg;

  localparam int unsigned BURST_MAX = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_WBURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       port;
    logic [4:0] size;
  } rdq_entry_t;

endpackage

// File: rtl/mcpu_mem_arb_if.sv
// Avalon-MM burst port bundle; the command source uses master, the command sink uses slave.
interface mcpu_mem_arb_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] be;
  logic                burstbegin;
  logic                read_req;
  logic                write_req;
  logic [4:0]          size;
  logic [DATA_W-1:0]   wdata;
  logic                ready;
  logic [DATA_W-1:0]   rdata;
  logic                rdata_valid;

  modport master (
    output addr, be, burstbegin, read_req, write_req, size, wdata,
    input  ready, rdata, rdata_valid
  );

  modport slave (
    input  addr, be, burstbegin, read_req, write_req, size, wdata,
    output ready, rdata, rdata_valid
  );
endinterface

// File: rtl/mcpu_mem_arb_rdq.sv
// In-order queue of outstanding read bursts {port, size}; push and pop may share a cycle.
module mcpu_mem_arb_rdq
  import mcpu_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rdq_entry_t push_data_i,
  input  logic       pop_i,
  output rdq_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  rdq_entry_t    mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok_s, pop_ok_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q[PW-1:0]];

  // pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // entry storage
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end
endmodule

// File: rtl/mcpu_mem_arb.sv
// Two-master burst arbiter for the DRAM controller Avalon port with in-order read return routing.
// Build option: MCPU_MEM_ARB_FIXPRIO_EN gives port 0 fixed priority instead of round-robin.
module mcpu_mem_arb
  import mcpu_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned RDQ_DEPTH = 4
) (
  input  logic            clkrst_mem_clk,
  input  logic            clkrst_mem_rst,
  mcpu_mem_arb_if.slave   p0_avl,
  mcpu_mem_arb_if.slave   p1_avl,
  mcpu_mem_arb_if.master  mc_avl,
  output logic            arb_rd_unexp
);
  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic [4:0] wcnt_q, wcnt_d;
  logic [4:0] rd_beat_q, rd_beat_d;
  logic       unexp_q, unexp_d;

  logic       elig0_s, elig1_s, sel_s, grant_s, is_rd_s;
  logic       rdq_full_s, rdq_empty_s, rdq_push_s, rdq_pop_s, rd_hit_s;
  rdq_entry_t rdq_head_s, rdq_push_data_s;
  logic [4:0] beat_inc_s;

  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W/8-1:0] sel_be_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [4:0]          sel_size_s;
  logic                sel_bb_s, sel_rd_s, sel_wr_s;

  // A port holding both requests is treated as a read; it never asserts both legally.
  assign elig0_s = p0_avl.read_req ? ~rdq_full_s : (p0_avl.write_req & p0_avl.burstbegin);
  assign elig1_s = p1_avl.read_req ? ~rdq_full_s : (p1_avl.write_req & p1_avl.burstbegin);

  // winner selection
  always_comb begin
    sel_s   = 1'b0;
    grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0_s & elig1_s) begin
`ifdef MCPU_MEM_ARB_FIXPRIO_EN
          sel_s = 1'b0;
`else
          sel_s = ~last_q;
`endif
        end else if (elig1_s) begin
          sel_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end
        grant_s = elig0_s | elig1_s;
      end
      ST_WBURST: begin
        sel_s   = lock_q;
        grant_s = lock_q ? p1_avl.write_req : p0_avl.write_req;
      end
      default: begin
        sel_s   = 1'b0;
        grant_s = 1'b0;
      end
    endcase
  end

  assign sel_addr_s  = sel_s ? p1_avl.addr       : p0_avl.addr;
  assign sel_be_s    = sel_s ? p1_avl.be         : p0_avl.be;
  assign sel_wdata_s = sel_s ? p1_avl.wdata      : p0_avl.wdata;
  assign sel_size_s  = sel_s ? p1_avl.size       : p0_avl.size;
  assign sel_bb_s    = sel_s ? p1_avl.burstbegin : p0_avl.burstbegin;
  assign sel_rd_s    = sel_s ? p1_avl.read_req   : p0_avl.read_req;
  assign sel_wr_s    = sel_s ? p1_avl.write_req  : p0_avl.write_req;
  assign is_rd_s     = (state_q == ST_IDLE) & sel_rd_s;

  assign mc_avl.addr       = sel_addr_s;
  assign mc_avl.be         = sel_be_s;
  assign mc_avl.wdata      = sel_wdata_s;
  assign mc_avl.size       = sel_size_s;
  assign mc_avl.burstbegin = grant_s & sel_bb_s;
  assign mc_avl.read_req   = grant_s & is_rd_s;
  assign mc_avl.write_req  = grant_s & ~is_rd_s & sel_wr_s;

  assign p0_avl.ready = grant_s & ~sel_s & mc_avl.ready;
  assign p1_avl.ready = grant_s &  sel_s & mc_avl.ready;

  assign rdq_push_data_s = '{port: sel_s, size: sel_size_s};

  // burst FSM next-state
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_d     = lock_q;
    wcnt_d     = wcnt_q;
    rdq_push_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s & mc_avl.ready) begin
          if (is_rd_s) begin
            rdq_push_s = 1'b1;
            last_d     = sel_s;
          end else if (sel_size_s == 5'd1) begin
            last_d = sel_s;
          end else begin
            wcnt_d  = sel_size_s - 5'd1;
            lock_d  = sel_s;
            state_d = ST_WBURST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WBURST: begin
        if (grant_s & mc_avl.ready) begin
          if (wcnt_q == 5'd1) begin
            last_d  = lock_q;
            wcnt_d  = 5'd0;
            state_d = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q - 5'd1;
          end
        end else begin
          state_d = ST_WBURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Return beats follow the queue head; beats with nothing outstanding are dropped.
  assign rd_hit_s   = mc_avl.rdata_valid & ~rdq_empty_s;
  assign beat_inc_s = rd_beat_q + 5'd1;
  assign rdq_pop_s  = rd_hit_s & (beat_inc_s == rdq_head_s.size);

  assign p0_avl.rdata       = mc_avl.rdata;
  assign p1_avl.rdata       = mc_avl.rdata;
  assign p0_avl.rdata_valid = rd_hit_s & ~rdq_head_s.port;
  assign p1_avl.rdata_valid = rd_hit_s &  rdq_head_s.port;

  // read beat counter and unexpected-beat flag next-state
  always_comb begin
    rd_beat_d = rd_beat_q;
    unexp_d   = unexp_q | (mc_avl.rdata_valid & rdq_empty_s);
    if (rdq_pop_s) begin
      rd_beat_d = 5'd0;
    end else if (rd_hit_s) begin
      rd_beat_d = beat_inc_s;
    end else begin
      rd_beat_d = rd_beat_q;
    end
  end

  // state registers
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      wcnt_q    <= 5'd0;
      rd_beat_q <= 5'd0;
      unexp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      wcnt_q    <= wcnt_d;
      rd_beat_q <= rd_beat_d;
      unexp_q   <= unexp_d;
    end
  end

  assign arb_rd_unexp = unexp_q;

  mcpu_mem_arb_rdq #(
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .clk_i       (clkrst_mem_clk),
    .rst_i       (clkrst_mem_rst),
    .push_i      (rdq_push_s),
    .push_data_i (rdq_push_data_s),
    .pop_i       (rdq_pop_s),
    .head_o      (rdq_head_s),
    .full_o      (rdq_full_s),
    .empty_o     (rdq_empty_s)
  );
endmodule
